// File: rtl/swizzle_cram_to_dram_if.sv
// Bundles the CRAM read port, the memory-controller stream and the control
// handshake of swizzle_cram_to_dram into one parameterised interface.
interface swizzle_cram_to_dram_if #(
  parameter int DWIDTH     = 40,
  parameter int RAM_AWIDTH = 12,
  parameter int NBLK_WIDTH = 8
);
  logic                  start;
  logic [RAM_AWIDTH-1:0] ram_start_addr;
  logic [NBLK_WIDTH-1:0] num_blocks;
  logic [RAM_AWIDTH-1:0] ram_addr;
  logic                  ram_rd_en;
  logic [DWIDTH-1:0]     ram_data_in;
  logic [DWIDTH-1:0]     mem_ctrl_data_out;
  logic                  mem_ctrl_valid;
  logic                  mem_ctrl_ready;
  logic                  mem_ctrl_last;
  logic                  busy;
  logic                  done;

  modport master (
    input  start, ram_start_addr, num_blocks, ram_data_in, mem_ctrl_ready,
    output ram_addr, ram_rd_en, mem_ctrl_data_out, mem_ctrl_valid,
           mem_ctrl_last, busy, done
  );

  modport slave (
    output start, ram_start_addr, num_blocks, ram_data_in, mem_ctrl_ready,
    input  ram_addr, ram_rd_en, mem_ctrl_data_out, mem_ctrl_valid,
           mem_ctrl_last, busy, done
  );
endinterface

// File: rtl/swizzle_cram_to_dram.sv
// Reads DWIDTH-word blocks from compute RAM into ping/pong transpose buffers
// and streams each buffer out column by column as a bit-reversed transpose.
module swizzle_cram_to_dram #(
  parameter int DWIDTH      = 40,
  parameter int RAM_AWIDTH  = 12,
  parameter int NBLK_WIDTH  = 8,
  parameter int ADDR_STRIDE = 4
) (
  input logic                   clk,
  input logic                   resetn,
  swizzle_cram_to_dram_if.master bus
);
  localparam int CW = $clog2(DWIDTH);
  localparam logic [CW-1:0]         LAST_IDX = CW'(DWIDTH - 1);
  localparam logic [CW-1:0]         ONE_IDX  = CW'(1);
  localparam logic [NBLK_WIDTH-1:0] ONE_BLK  = NBLK_WIDTH'(1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_READ = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  // Fill side
  logic [1:0]            state_q, state_d;
  logic [CW-1:0]         k_q, k_d;
  logic [NBLK_WIDTH-1:0] blk_q, blk_d, nblk_q, nblk_d;
  logic [RAM_AWIDTH-1:0] base_q, base_d;
  logic                  fill_buf_q, fill_buf_d;
  logic                  cap_vld_q, cap_vld_d, cap_buf_q, cap_buf_d;
  logic [CW-1:0]         cap_row_q, cap_row_d;
  // Drain side
  logic [1:0]            full_q, full_d;
  logic                  valid_q, valid_d, last_q, last_d;
  logic                  busy_q, busy_d, done_q, done_d;
  logic                  drain_buf_q, drain_buf_d;
  logic [CW-1:0]         col_q, col_d;
  logic [NBLK_WIDTH-1:0] dblk_q, dblk_d;
  logic [DWIDTH-1:0]     data_q, data_d;

  logic [DWIDTH-1:0]     buf_mem [2][DWIDTH];

  logic                  accept, fire, drain_free;
  logic [1:0]            free_vec;
  logic                  pres_en, pres_buf;
  logic [CW-1:0]         pres_col, pres_bit;
  logic [NBLK_WIDTH-1:0] pres_blk;
  logic [DWIDTH-1:0]     pres_word;

  assign accept     = bus.start && !busy_q;
  assign fire       = valid_q && bus.mem_ctrl_ready;
  assign drain_free = fire && (col_q == LAST_IDX);

  // A buffer may be refilled once empty or in the cycle its last column is
  // accepted: the first read's data only lands one cycle later.
  always_comb begin
    for (int i = 0; i < 2; i++)
      free_vec[i] = !full_q[i] || (drain_free && (drain_buf_q == i[0]));
  end

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    blk_d      = blk_q;
    nblk_d     = nblk_q;
    base_d     = base_q;
    fill_buf_d = fill_buf_q;
    case (state_q)
      S_IDLE: if (accept && bus.num_blocks != '0) begin
        base_d     = bus.ram_start_addr;
        nblk_d     = bus.num_blocks;
        blk_d      = '0;
        k_d        = '0;
        fill_buf_d = 1'b0;
        state_d    = S_READ;
      end
      S_READ: if (k_q == LAST_IDX) begin
        k_d = '0;
        if (blk_q == nblk_q - ONE_BLK) begin
          state_d = S_IDLE;
        end else begin
          blk_d      = blk_q + ONE_BLK;
          fill_buf_d = !fill_buf_q;
          state_d    = free_vec[!fill_buf_q] ? S_READ : S_WAIT;
        end
      end else begin
        k_d = k_q + ONE_IDX;
      end
      S_WAIT: if (free_vec[fill_buf_q]) state_d = S_READ;
      default: state_d = S_IDLE;
    endcase

    cap_vld_d = (state_q == S_READ);
    cap_row_d = k_q;
    cap_buf_d = fill_buf_q;
  end

  always_comb begin
    full_d      = full_q;
    valid_d     = valid_q;
    last_d      = last_q;
    data_d      = data_q;
    col_d       = col_q;
    drain_buf_d = drain_buf_q;
    dblk_d      = dblk_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    pres_en     = 1'b0;
    pres_buf    = drain_buf_q;
    pres_col    = '0;
    pres_blk    = dblk_q;
    pres_bit    = '0;
    pres_word   = '0;

    if (cap_vld_q && cap_row_q == LAST_IDX) full_d[cap_buf_q] = 1'b1;

    if (accept) begin
      busy_d      = (bus.num_blocks != '0);
      done_d      = (bus.num_blocks == '0);
      drain_buf_d = 1'b0;
      dblk_d      = '0;
    end

    if (fire) begin
      if (col_q != LAST_IDX) begin
        pres_en  = 1'b1;
        pres_col = col_q + ONE_IDX;
      end else begin
        full_d[drain_buf_q] = 1'b0;
        dblk_d              = dblk_q + ONE_BLK;
        drain_buf_d         = !drain_buf_q;
        if (last_q) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else if (full_q[!drain_buf_q]) begin
          pres_en  = 1'b1;
          pres_buf = !drain_buf_q;
          pres_blk = dblk_q + ONE_BLK;
        end else begin
          valid_d = 1'b0;
          last_d  = 1'b0;
        end
      end
    end else if (!valid_q && full_q[drain_buf_q]) begin
      pres_en = 1'b1;
    end

    // Column j takes bit DWIDTH-1-j of every row: a bit-reversed transpose.
    pres_bit = LAST_IDX - pres_col;
    for (int k = 0; k < DWIDTH; k++) pres_word[k] = buf_mem[pres_buf][k][pres_bit];

    if (pres_en) begin
      valid_d = 1'b1;
      col_d   = pres_col;
      data_d  = pres_word;
      last_d  = (pres_col == LAST_IDX) && (pres_blk == nblk_q - ONE_BLK);
    end
  end

  // NOTE: the transpose storage has no reset; only the full flags matter for
  // correctness, and leaving the array unreset lets it map to plain storage.
  always_ff @(posedge clk) begin
    if (cap_vld_q) buf_mem[cap_buf_q][cap_row_q] <= bus.ram_data_in;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      blk_q       <= '0;
      nblk_q      <= '0;
      base_q      <= '0;
      fill_buf_q  <= 1'b0;
      cap_vld_q   <= 1'b0;
      cap_row_q   <= '0;
      cap_buf_q   <= 1'b0;
      full_q      <= '0;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      drain_buf_q <= 1'b0;
      col_q       <= '0;
      dblk_q      <= '0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      blk_q       <= blk_d;
      nblk_q      <= nblk_d;
      base_q      <= base_d;
      fill_buf_q  <= fill_buf_d;
      cap_vld_q   <= cap_vld_d;
      cap_row_q   <= cap_row_d;
      cap_buf_q   <= cap_buf_d;
      full_q      <= full_d;
      valid_q     <= valid_d;
      last_q      <= last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      drain_buf_q <= drain_buf_d;
      col_q       <= col_d;
      dblk_q      <= dblk_d;
      data_q      <= data_d;
    end
  end

  assign bus.ram_rd_en         = (state_q == S_READ);
  assign bus.ram_addr          = bus.ram_rd_en
                               ? base_q + RAM_AWIDTH'(blk_q) + RAM_AWIDTH'(ADDR_STRIDE * k_q)
                               : '0;
  assign bus.mem_ctrl_data_out = data_q;
  assign bus.mem_ctrl_valid    = valid_q;
  assign bus.mem_ctrl_last     = last_q;
  assign bus.busy              = busy_q;
  assign bus.done              = done_q;
endmodule

// File: tb/tb_swizzle_cram_to_dram.sv
// Randomised scoreboard bench for swizzle_cram_to_dram: a CRAM model answers
// reads, and expected addresses and words are derived from the transfer rules.
module tb_swizzle_cram_to_dram;
  localparam int DW = 40;
  localparam int AW = 12;
  localparam int NW = 8;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  swizzle_cram_to_dram_if #(.DWIDTH(DW), .RAM_AWIDTH(AW), .NBLK_WIDTH(NW)) bus ();

  swizzle_cram_to_dram #(
    .DWIDTH(DW), .RAM_AWIDTH(AW), .NBLK_WIDTH(NW), .ADDR_STRIDE(4)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .bus(bus)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  exp_t          exp_q[$];
  logic [AW-1:0] addr_q[$];
  logic [DW-1:0] cram [1<<AW];

  int total = 0, bad = 0;
  int done_cnt = 0, popped = 0, rd_cnt = 0, cyc = 0;
  int stall_pct = 0, first_fire = -1, last_fire = -1;
  bit            stalled = 1'b0;
  logic [DW-1:0] st_data;
  logic          st_last;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // CRAM model: data for the address presented in one cycle appears the next.
  always @(posedge clk) bus.ram_data_in <= cram[bus.ram_addr];

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1 bus.mem_ctrl_ready = ($urandom_range(99) >= stall_pct);
  end

  // Reference: block b word k lives at base+b+4k; output column j of block b
  // holds bit DW-1-j of each of that block's words, word k at bit k.
  task automatic push_model(input logic [AW-1:0] base, input int n);
    exp_t          e;
    logic [DW-1:0] w, row;
    for (int b = 0; b < n; b++)
      for (int k = 0; k < DW; k++) addr_q.push_back(AW'(int'(base) + b + 4 * k));
    for (int b = 0; b < n; b++)
      for (int j = 0; j < DW; j++) begin
        w = '0;
        for (int k = 0; k < DW; k++) begin
          row  = cram[AW'(int'(base) + b + 4 * k)];
          w[k] = row[DW-1-j];
        end
        e.data = w;
        e.last = (b == n - 1) && (j == DW - 1);
        exp_q.push_back(e);
      end
  endtask

  // Monitor: compares reads and output words against the scoreboard queues.
  always @(negedge clk) begin
    if (!resetn) begin
      stalled = 1'b0;
    end else begin
      if (bus.ram_rd_en) begin
        rd_cnt++;
        if (addr_q.size() == 0) check("rd_en_unexpected", bus.ram_rd_en, 0);
        else check("rd_addr", bus.ram_addr, addr_q.pop_front());
      end
      if (stalled) begin
        check("stall_valid", bus.mem_ctrl_valid, 1);
        check("stall_data", bus.mem_ctrl_data_out, st_data);
        check("stall_last", bus.mem_ctrl_last, st_last);
      end
      if (bus.mem_ctrl_valid && bus.mem_ctrl_ready) begin
        if (exp_q.size() == 0) begin
          check("word_unexpected", bus.mem_ctrl_valid, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("word_data", bus.mem_ctrl_data_out, e.data);
          check("word_last", bus.mem_ctrl_last, e.last);
        end
        popped++;
        if (first_fire < 0) first_fire = cyc;
        last_fire = cyc;
      end
      stalled = bus.mem_ctrl_valid && !bus.mem_ctrl_ready;
      st_data = bus.mem_ctrl_data_out;
      st_last = bus.mem_ctrl_last;
      if (bus.done) begin
        done_cnt++;
        check("busy_at_done", bus.busy, 0);
        check("words_left_at_done", exp_q.size(), 0);
      end
    end
  end

  task automatic do_start(input logic [AW-1:0] base, input int n, input bit accepted);
    @(posedge clk);
    #1;
    if (accepted) push_model(base, n);
    bus.start          = 1'b1;
    bus.ram_start_addr = base;
    bus.num_blocks     = NW'(n);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    if (accepted && n != 0) check("busy_rise", bus.busy, 1);
  endtask

  task automatic wait_done(input int target, input string name);
    int c = 0;
    while (done_cnt < target && c < 3000) begin
      @(posedge clk);
      c++;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check({name, "_done_cnt"}, done_cnt, target);
    check({name, "_words_left"}, exp_q.size(), 0);
    check({name, "_reads_left"}, addr_q.size(), 0);
    check({name, "_busy_idle"}, bus.busy, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int            exp_done = 0;
    int            rd_before, p0, c, span;
    logic [DW-1:0] one_hot;

    bus.start          = 1'b0;
    bus.ram_start_addr = '0;
    bus.num_blocks     = '0;
    bus.mem_ctrl_ready = 1'b1;
    for (int i = 0; i < (1 << AW); i++) cram[i] = DW'({$urandom(), $urandom()});

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_rd_en", bus.ram_rd_en, 0);
    check("reset_addr", bus.ram_addr, 0);
    check("reset_valid", bus.mem_ctrl_valid, 0);
    check("reset_last", bus.mem_ctrl_last, 0);
    check("reset_data", bus.mem_ctrl_data_out, 0);
    check("reset_busy", bus.busy, 0);
    check("reset_done", bus.done, 0);
    @(posedge clk);
    #1 resetn = 1'b1;

    // Transpose of a one-hot diagonal block
    one_hot = 1;
    for (int k = 0; k < DW; k++) cram[AW'(16 + 4 * k)] = one_hot << (DW - 1 - k);
    stall_pct = 0;
    do_start(12'h010, 1, 1'b1);
    exp_done++;
    wait_done(exp_done, "transpose");

    // Address wrap-around
    do_start(12'hFF0, 3, 1'b1);
    exp_done++;
    wait_done(exp_done, "addr_wrap");

    // Random backpressure
    stall_pct = 30;
    do_start(AW'($urandom()), 4, 1'b1);
    exp_done++;
    wait_done(exp_done, "backpressure");
    stall_pct = 0;

    // Sustained throughput with ready held high
    repeat (2) @(posedge clk);
    first_fire = -1;
    do_start(AW'($urandom()), 8, 1'b1);
    exp_done++;
    wait_done(exp_done, "throughput");
    span = last_fire - first_fire + 1;
    check("tput_span_within_331", (span <= 8 * 41 + 3), 1);

    // Start while busy is ignored
    do_start(12'h123, 2, 1'b1);
    repeat (20) @(posedge clk);
    do_start(12'h456, 3, 1'b0);
    exp_done++;
    wait_done(exp_done, "start_busy");

    // Zero blocks: done next cycle, no reads, busy stays low
    rd_before = rd_cnt;
    do_start(12'h321, 0, 1'b1);
    check("zero_blk_done", bus.done, 1);
    check("zero_blk_busy", bus.busy, 0);
    exp_done++;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("zero_blk_reads", rd_cnt - rd_before, 0);
    check("zero_blk_done_cnt", done_cnt, exp_done);

    // Reset in the middle of block 1, then a clean transfer
    p0 = popped;
    c  = 0;
    do_start(12'h200, 3, 1'b1);
    while (popped < p0 + 60 && c < 1000) begin
      @(posedge clk);
      c++;
    end
    check("mid_reached", (popped >= p0 + 60), 1);
    @(posedge clk);
    #1 resetn = 1'b0;
    exp_q.delete();
    addr_q.delete();
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_rd_en", bus.ram_rd_en, 0);
    check("mid_rst_addr", bus.ram_addr, 0);
    check("mid_rst_valid", bus.mem_ctrl_valid, 0);
    check("mid_rst_last", bus.mem_ctrl_last, 0);
    check("mid_rst_data", bus.mem_ctrl_data_out, 0);
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_done", bus.done, 0);
    @(posedge clk);
    #1 resetn = 1'b1;
    do_start(12'h7A0, 1, 1'b1);
    exp_done++;
    wait_done(exp_done, "after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
